// File: rtl/ptp_slot_scheduler.sv
// Time-slot scheduler for ultrasonic PTP channels sharing one piezo medium.
// Grants one channel at a time (round robin), pulses its reset, runs it until
// it reports convergence or times out, captures its travel time, and then
// keeps the medium quiet for a guard period so echoes decay before the next slot.
module ptp_slot_scheduler #(
  parameter int N_CH           = 4,
  parameter int GUARD_CYCLES   = 7000,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_CH-1:0]      req,
  input  logic [N_CH-1:0]      done,
  input  logic [32*N_CH-1:0]   meas,
  output logic [N_CH-1:0]      grant,
  output logic                 ch_reset,
  output logic                 busy,
  output logic                 res_valid,
  output logic [2:0]           res_ch,
  output logic [31:0]          res_time,
  output logic                 timeout_err,
  output logic [15:0]          timeout_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_CAPTURE,
    S_GUARD
  } state_t;

  localparam logic [31:0]     RUN_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]     GUARD_LAST = 32'(GUARD_CYCLES - 1);
  localparam logic [N_CH-1:0] CH_ONE     = {{(N_CH-1){1'b0}}, 1'b1};

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      cur;
  logic [2:0]      rr_ptr;
  logic [31:0]     cnt;

  logic [N_CH-1:0] req_rot;
  logic            found;
  logic [2:0]      pick;
  logic [N_CH-1:0] cur_onehot;
  logic            done_cur;
  logic [31:0]     meas_cur;
  logic            run_last;
  logic            guard_last;
  logic            timeout_hit;

  // Channel index addition wrapping modulo N_CH.
  function automatic logic [2:0] wrap_add(input logic [2:0] base, input logic [2:0] off);
    logic [3:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 4'(N_CH)) s = s - 4'(N_CH);
    return s[2:0];
  endfunction

  // Saturating increment for the 16-bit timeout counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the lowest set bit.
  always_comb begin
    req_rot = N_CH'({req, req} >> rr_ptr);
    found   = 1'b0;
    pick    = rr_ptr;
    for (int j = 0; j < N_CH; j++) begin
      if (!found && req_rot[j]) begin
        found = 1'b1;
        pick  = wrap_add(rr_ptr, 3'(j));
      end
    end
  end

  // Per-slot views of the current channel: its one-hot, done flag and measurement.
  always_comb begin
    cur_onehot = CH_ONE << cur;
    done_cur   = |(done & cur_onehot);
    meas_cur   = 32'd0;
    for (int k = 0; k < N_CH; k++) begin
      if (cur == 3'(k)) meas_cur = meas[32*k +: 32];
    end
    run_last    = (cnt == RUN_LAST);
    guard_last  = (cnt == GUARD_LAST);
    timeout_hit = (state == S_RUN) && enable && !done_cur && run_last;
  end

  // Next-state logic and state-decoded outputs; grant drops with reset since it is decoded from state.
  always_comb begin
    state_nxt = state;
    grant     = '0;
    ch_reset  = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (enable && found) state_nxt = S_ARM;
      end
      S_ARM: begin
        ch_reset  = 1'b1;
        state_nxt = enable ? S_RUN : S_GUARD;
      end
      S_RUN: begin
        grant = cur_onehot;
        if (!enable)       state_nxt = S_GUARD;
        else if (done_cur) state_nxt = S_CAPTURE;
        else if (run_last) state_nxt = S_GUARD;
      end
      S_CAPTURE: begin
        grant     = cur_onehot;
        state_nxt = S_GUARD;
      end
      S_GUARD: begin
        if (guard_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, slot bookkeeping and the shared run/guard cycle counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cur    <= 3'd0;
      rr_ptr <= 3'd0;
      cnt    <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (state_nxt == S_ARM) cur <= pick;
          cnt <= 32'd0;
        end
        S_ARM: cnt <= 32'd0;
        S_RUN: cnt <= (state_nxt == S_RUN) ? cnt + 32'd1 : 32'd0;
        S_CAPTURE: cnt <= 32'd0;
        S_GUARD: begin
          cnt <= cnt + 32'd1;
          if (state_nxt == S_IDLE) rr_ptr <= wrap_add(cur, 3'd1);
        end
        default: cnt <= 32'd0;
      endcase
    end
  end

  // Result capture and one-cycle strobes; res_valid is high during the CAPTURE cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_valid   <= 1'b0;
      res_ch      <= 3'd0;
      res_time    <= 32'd0;
      timeout_err <= 1'b0;
      timeout_cnt <= 16'd0;
    end else begin
      res_valid   <= 1'b0;
      timeout_err <= 1'b0;
      if (state == S_RUN && state_nxt == S_CAPTURE) begin
        res_valid <= 1'b1;
        res_ch    <= cur;
        res_time  <= meas_cur;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
        timeout_cnt <= sat_inc16(timeout_cnt);
      end
    end
  end

endmodule

// File: tb/tb_ptp_slot_scheduler.sv
// Self-checking bench for ptp_slot_scheduler: round robin, capture, timeout,
// abort and asynchronous reset scenarios, with a result scoreboard.
module tb_ptp_slot_scheduler;

  localparam int N_CH = 4;
  localparam int GC   = 10;
  localparam int TO   = 100;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                enable = 1'b0;
  logic [N_CH-1:0]     req = '0;
  logic [N_CH-1:0]     done = '0;
  logic [31:0]         meas_w [N_CH];
  logic [32*N_CH-1:0]  meas;
  logic [N_CH-1:0]     grant;
  logic                ch_reset;
  logic                busy;
  logic                res_valid;
  logic [2:0]          res_ch;
  logic [31:0]         res_time;
  logic                timeout_err;
  logic [15:0]         timeout_cnt;

  int checks   = 0;
  int failures = 0;
  int rv_seen  = 0;
  int te_seen  = 0;

  typedef struct {
    logic [2:0]  ch;
    logic [31:0] t;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  assign meas = {meas_w[3], meas_w[2], meas_w[1], meas_w[0]};

  always #5 clock = ~clock;

  ptp_slot_scheduler #(
    .N_CH(N_CH),
    .GUARD_CYCLES(GC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .req(req),
    .done(done),
    .meas(meas),
    .grant(grant),
    .ch_reset(ch_reset),
    .busy(busy),
    .res_valid(res_valid),
    .res_ch(res_ch),
    .res_time(res_time),
    .timeout_err(timeout_err),
    .timeout_cnt(timeout_cnt)
  );

  // Result scoreboard and grant one-hot monitor, sampled on the falling edge.
  always @(negedge clock) begin
    if (res_valid) begin
      rv_seen++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL res_unexpected: got ch=%0d time=%0d, required no result", res_ch, res_time);
      end else begin
        mon_e = sb.pop_front();
        if (res_ch !== mon_e.ch || res_time !== mon_e.t) begin
          failures++;
          $display("FAIL res_data: got ch=%0d time=%0d, required ch=%0d time=%0d",
                   res_ch, res_time, mon_e.ch, mon_e.t);
        end
      end
    end
    if (timeout_err) te_seen++;
    if (grant != '0) begin
      checks++;
      if (!$onehot(grant)) begin
        failures++;
        $display("FAIL grant_onehot: got %b, required one bit set", grant);
      end
    end
  end

  function automatic logic [N_CH-1:0] oh(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    req    = '0;
    done   = '0;
    for (int i = 0; i < N_CH; i++) meas_w[i] = 32'd0;
    step();
    step();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic wait_ch_reset(input string name, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      n++;
      if (ch_reset) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_wait: no ch_reset within 400 cycles, required a pulse", name);
    end
  endtask

  // One complete slot on channel ch ending with done after dly RUN cycles.
  task automatic run_slot(input string name, input logic [1:0] ch, input logic [31:0] m, input int dly);
    int n;
    bit ok;
    wait_ch_reset(name, n, ok);
    if (!ok) return;
    checks++;
    if (grant !== '0) begin
      failures++;
      $display("FAIL %s_arm_grant: got %b, required 0000", name, grant);
    end
    step();
    checks++;
    if (grant !== oh(ch) || ch_reset !== 1'b0) begin
      failures++;
      $display("FAIL %s_grant: got grant=%b ch_reset=%b, required grant=%b ch_reset=0", name, grant, ch_reset, oh(ch));
    end
    repeat (dly) step();
    meas_w[ch] = m;
    done[ch]   = 1'b1;
    sb.push_back('{ch: {1'b0, ch}, t: m});
    step();
    checks++;
    if (res_valid !== 1'b1 || grant !== oh(ch)) begin
      failures++;
      $display("FAIL %s_capture: got res_valid=%b grant=%b, required 1 and %b", name, res_valid, grant, oh(ch));
    end
    done[ch] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (grant !== '0 || ch_reset !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got grant=%b ch_reset=%b busy=%b, required 0", grant, ch_reset, busy);
    end
    checks++;
    if (res_valid !== 1'b0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes: got res_valid=%b timeout_err=%b, required 0", res_valid, timeout_err);
    end
    checks++;
    if (res_ch !== 3'd0 || res_time !== 32'd0 || timeout_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_data: got res_ch=%0d res_time=%0d timeout_cnt=%0d, required 0", res_ch, res_time, timeout_cnt);
    end
    reset  = 1'b0;
    enable = 1'b1;
    repeat (3) step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    enable = 1'b1;
    req    = 4'b0101;
    run_slot("rr0", 2'd0, 32'h11, 2);
    run_slot("rr1", 2'd2, 32'h22, 2);
    run_slot("rr2", 2'd0, 32'h33, 2);
  endtask

  task automatic test_capture();
    int n;
    int g;
    bit ok;
    do_reset();
    enable = 1'b1;
    req    = 4'b0100;
    wait_ch_reset("cap", n, ok);
    if (!ok) return;
    step();
    checks++;
    if (grant !== 4'b0100) begin
      failures++;
      $display("FAIL cap_grant: got %b, required 0100", grant);
    end
    req = 4'b0000;
    repeat (19) step();
    meas_w[2] = 32'd1234;
    done[2]   = 1'b1;
    sb.push_back('{ch: 3'd2, t: 32'd1234});
    step();
    checks++;
    if (res_valid !== 1'b1 || grant !== 4'b0100) begin
      failures++;
      $display("FAIL cap_strobe: got res_valid=%b grant=%b, required 1 and 0100", res_valid, grant);
    end
    done[2] = 1'b0;
    g = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (!busy) break;
      if (grant == '0) g++;
    end
    checks++;
    if (g != GC) begin
      failures++;
      $display("FAIL cap_guard_len: got %0d quiet cycles, required %0d", g, GC);
    end
    meas_w[2] = 32'd9;
    step();
    checks++;
    if (res_ch !== 3'd2 || res_time !== 32'd1234 || res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL cap_hold: got ch=%0d time=%0d valid=%b busy=%b, required 2 1234 0 0",
               res_ch, res_time, res_valid, busy);
    end
  endtask

  task automatic test_timeout();
    int n;
    int base_rv;
    int base_te;
    bit ok;
    do_reset();
    enable = 1'b1;
    req    = 4'b0010;
    wait_ch_reset("to", n, ok);
    if (!ok) return;
    step();
    base_rv = rv_seen;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      n++;
      if (timeout_err) break;
    end
    checks++;
    if (n != TO || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL to_latency: got %0d cycles err=%b, required %0d and 1", n, timeout_err, TO);
    end
    checks++;
    if (timeout_cnt !== 16'd1 || grant !== '0 || rv_seen != base_rv) begin
      failures++;
      $display("FAIL to_state: got cnt=%0d grant=%b results=%0d, required 1 0000 %0d",
               timeout_cnt, grant, rv_seen, base_rv);
    end
    base_te = te_seen;
    req = 4'b1010;
    wait_ch_reset("to_next", n, ok);
    if (!ok) return;
    checks++;
    if (n != GC + 1) begin
      failures++;
      $display("FAIL to_next_gap: got %0d cycles, required %0d", n, GC + 1);
    end
    step();
    checks++;
    if (grant !== 4'b1000) begin
      failures++;
      $display("FAIL to_next_grant: got %b, required 1000", grant);
    end
    repeat (4) step();
    done[1] = 1'b1;
    step();
    checks++;
    if (grant !== 4'b1000 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL other_done: got grant=%b res_valid=%b, required 1000 0", grant, res_valid);
    end
    done[1] = 1'b0;
    repeat (94) step();
    meas_w[3] = 32'd777;
    done[3]   = 1'b1;
    sb.push_back('{ch: 3'd3, t: 32'd777});
    step();
    checks++;
    if (res_valid !== 1'b1 || timeout_err !== 1'b0 || timeout_cnt !== 16'd1) begin
      failures++;
      $display("FAIL done_vs_to: got valid=%b err=%b cnt=%0d, required 1 0 1", res_valid, timeout_err, timeout_cnt);
    end
    done[3] = 1'b0;
    step();
    checks++;
    if (te_seen != base_te) begin
      failures++;
      $display("FAIL done_vs_to_err: got %0d timeout strobes, required %0d", te_seen, base_te);
    end
  endtask

  task automatic test_abort();
    int n;
    int g;
    int base_rv;
    int base_te;
    bit ok;
    do_reset();
    enable = 1'b1;
    req    = 4'b0001;
    wait_ch_reset("ab", n, ok);
    if (!ok) return;
    step();
    base_rv = rv_seen;
    base_te = te_seen;
    repeat (5) step();
    enable = 1'b0;
    step();
    checks++;
    if (grant !== '0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL ab_drop: got grant=%b busy=%b, required 0000 1", grant, busy);
    end
    g = 1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (!busy) break;
      g++;
    end
    checks++;
    if (g != GC || busy !== 1'b0) begin
      failures++;
      $display("FAIL ab_guard: got %0d busy cycles busy=%b, required %0d 0", g, busy, GC);
    end
    checks++;
    if (rv_seen != base_rv || te_seen != base_te) begin
      failures++;
      $display("FAIL ab_strobes: got results=%0d timeouts=%0d, required %0d %0d", rv_seen, te_seen, base_rv, base_te);
    end
    enable = 1'b1;
    req    = 4'b0011;
    wait_ch_reset("ab_next", n, ok);
    if (!ok) return;
    step();
    checks++;
    if (grant !== 4'b0010) begin
      failures++;
      $display("FAIL ab_rr: got %b, required 0010", grant);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    int base_rv;
    bit ok;
    do_reset();
    enable = 1'b1;
    req    = 4'b0001;
    run_slot("pre", 2'd0, 32'hABCD, 3);
    for (int k = 0; k < 5; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
        step();
        if (timeout_err) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) break;
    end
    checks++;
    if (timeout_cnt !== 16'd5 || res_time !== 32'hABCD) begin
      failures++;
      $display("FAIL pre_state: got cnt=%0d time=%0h, required 5 abcd", timeout_cnt, res_time);
    end
    wait_ch_reset("mid", n, ok);
    if (!ok) return;
    step();
    repeat (3) step();
    base_rv = rv_seen;
    reset = 1'b1;
    #1;
    checks++;
    if (grant !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_async_grant: got grant=%b busy=%b, required 0000 0", grant, busy);
    end
    checks++;
    if (timeout_cnt !== 16'd0 || res_time !== 32'd0 || res_valid !== 1'b0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_async_data: got cnt=%0d time=%0d valid=%b err=%b, required 0",
               timeout_cnt, res_time, res_valid, timeout_err);
    end
    step();
    reset = 1'b0;
    req   = 4'b0011;
    wait_ch_reset("post", n, ok);
    if (!ok) return;
    step();
    checks++;
    if (grant !== 4'b0001 || rv_seen != base_rv) begin
      failures++;
      $display("FAIL rst_rr_ptr: got grant=%b results=%0d, required 0001 %0d", grant, rv_seen, base_rv);
    end
  endtask

  initial begin
    for (int i = 0; i < N_CH; i++) meas_w[i] = 32'd0;
    test_reset();
    test_round_robin();
    test_capture();
    test_timeout();
    test_abort();
    test_reset_mid_run();
    repeat (2) step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending results, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
